// File: rtl/rca_multibyte_seq.sv
// Multi-byte add/subtract sequencer: one 8-bit ripple-carry slice reused LSB first,
// with the inter-byte carry held in a register and valid/ready on both sides.
module rca_multibyte_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op_sub,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  zero,
    output logic                  busy
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [NBYTES-1:0][7:0]   a_q;
    logic [NBYTES-1:0][7:0]   b_q;
    logic [NBYTES-1:0][7:0]   result_q;
    logic [NBYTES-1:0][7:0]   result_d;
    logic [IW-1:0]            idx_q;
    logic                     carry_q;
    logic                     cout_q;
    logic                     ovf_q;
    logic                     zero_q;

    logic [7:0]               slice_a;
    logic [7:0]               slice_b;
    logic [7:0]               slice_sum;
    logic                     slice_cout;
    logic                     carry_into_msb;

    always_comb begin
        slice_a = a_q[idx_q];
        slice_b = b_q[idx_q];
        {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {8'b0, carry_q};
        // Carry into bit 7 of the slice recovered from the sum bit; only meaningful on the top byte.
        carry_into_msb = slice_a[7] ^ slice_b[7] ^ slice_sum[7];
        result_d = result_q;
        result_d[idx_q] = slice_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= op_sub ? ~b : b;
                        carry_q <= op_sub;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q <= result_d;
                    carry_q  <= slice_cout;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= slice_cout;
                        ovf_q   <= carry_into_msb ^ slice_cout;
                        zero_q  <= (result_d == '0);
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_rca_multibyte_seq.sv
// Bench for rca_multibyte_seq: directed vectors, randomized traffic against an
// arithmetic reference model, backpressure, mid-run operand change and mid-run reset.
module tb_rca_multibyte_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          op_sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          overflow;
    logic          zero;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int accept_cyc = 0;

    // Expected entries packed as {carry, overflow, zero, result}
    logic [W+2:0] exp_q[$];

    rca_multibyte_seq #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic sub);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         v;
        if (sub) full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else     full = {1'b0, x} + {1'b0, y};
        r = full[W-1:0];
        if (sub) v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        else     v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        return {full[W], v, (r == '0), r};
    endfunction

    // Drives one request from IDLE; returns just after the accept edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                        input logic [W+2:0] expv);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_in_ready got=%0b want=1", in_ready);
        end
        a = x; b = y; op_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        accept_cyc = cyc_cnt;
        exp_q.push_back(expv);
    endtask

    // Waits for the result, scores it against the queue head and completes the handshake.
    task automatic collect(input string name);
        logic [W+2:0] e;
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout out_valid=%0b after %0d cycles", name, out_valid, n);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (cyc_cnt - accept_cyc !== NBYTES) begin
            errors++;
            $display("FAIL %s_latency got=%0d want=%0d", name, cyc_cnt - accept_cyc, NBYTES);
        end
        checks++;
        if ({carry_out, overflow, zero, result} !== e) begin
            errors++;
            $display("FAIL %s_result got c=%0b v=%0b z=%0b r=%h want c=%0b v=%0b z=%0b r=%h",
                     name, carry_out, overflow, zero, result, e[W+2], e[W+1], e[W], e[W-1:0]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL %s_release got ov/ir/busy=%b want=010", name, {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy, carry_out, overflow, zero} !== 6'b100000 || result !== '0) begin
            errors++;
            $display("FAIL reset_state got ir/ov/busy/c/v/z=%b r=%h want 100000 r=0",
                     {in_ready, out_valid, busy, carry_out, overflow, zero}, result);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, {1'b0, 1'b0, 1'b0, 32'h0000_0100});
        collect("add_ff_1");
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
        collect("add_wrap");
        send(32'h8000_0000, 32'h0000_0001, 1'b1, {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF});
        collect("sub_ovf");
        send(32'h0000_0005, 32'h0000_0007, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
        collect("sub_borrow");
        send(32'h1234_5678, 32'h1234_5678, 1'b1, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
        collect("sub_equal");
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic         s;
        for (int i = 0; i < 40; i++) begin
            x = $urandom();
            y = $urandom();
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: y = ~x;
                1: y = x;
                2: x = {1'b1, {(W-1){1'b0}}};
                3: y = {1'b0, {(W-1){1'b1}}};
                default: ;
            endcase
            send(x, y, s, model(x, y, s));
            collect("random");
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held_r;
        logic [2:0]   held_f;
        send(32'hCAFE_0001, 32'h0101_0101, 1'b0, model(32'hCAFE_0001, 32'h0101_0101, 1'b0));
        repeat (NBYTES) @(posedge clk);
        #1;
        held_r = result;
        held_f = {carry_out, overflow, zero};
        checks++;
        if (held_r !== 32'hCBFF_0102) begin
            errors++;
            $display("FAIL bp_first_result got=%h want=cbff0102", held_r);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = $urandom(); b = $urandom(); op_sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || result !== held_r ||
                {carry_out, overflow, zero} !== held_f) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d ov/ir=%b r=%h want ov/ir=10 r=%h",
                         i, {out_valid, in_ready}, result, held_r);
            end
        end
        void'(exp_q.pop_front());
        a = 32'h0000_1000; b = 32'h0000_0234; op_sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL bp_release got ov/ir/busy=%b want=010", {out_valid, in_ready, busy});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        accept_cyc = cyc_cnt;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h0000_0DCC});
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept busy=%0b want=1", busy);
        end
        collect("bp_next");
    endtask

    task automatic test_operand_change();
        send(32'h1234_5678, 32'h1111_1111, 1'b0, {1'b0, 1'b0, 1'b0, 32'h2345_6789});
        in_valid = 1'b1;
        for (int i = 0; i < NBYTES - 1; i++) begin
            a = $urandom(); b = $urandom(); op_sub = ~op_sub;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        collect("op_change");
    endtask

    task automatic test_reset_mid_run();
        send(32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b0, model(32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        checks++;
        if ({in_ready, out_valid, busy, carry_out, overflow, zero} !== 6'b100000 || result !== '0) begin
            errors++;
            $display("FAIL midrun_reset got ir/ov/busy/c/v/z=%b r=%h want 100000 r=0",
                     {in_ready, out_valid, busy, carry_out, overflow, zero}, result);
        end
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
        collect("after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y;
        for (int i = 0; i < 6; i++) begin
            x = $urandom(); y = $urandom();
            send(x, y, 1'(i % 2), model(x, y, 1'(i % 2)));
            collect("back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_operand_change();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca_multibyte_seq.md
Name: rca_multibyte_seq

Overview:
- Sequencer that performs N×8-bit add/subtract by time-multiplexing one 8-bit ripple-carry adder slice, one byte per cycle, LSB first.
- Carry is registered between byte steps.
- Sits between the ALU operand registers and the ALU result mux.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- NBYTES, 4, operand width in bytes (W = 8*NBYTES); legal range 2..16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- op_sub  in  1  0 = A+B, 1 = A-B; sampled on accept
- a  in  W  operand A; sampled on accept
- b  in  W  operand B; sampled on accept
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  W  sum/difference
- carry_out  out  1  carry out of the MSB (for sub: 1 = no borrow)
- overflow  out  1  two's-complement signed overflow
- zero  out  1  result == 0
- busy  out  1  high in RUN

Behaviour:
- Reset (clk edge with rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - result=0; carry_out=0; overflow=0; zero=0.
  - Internal byte index and carry register = 0.
  - Reset wins over every other input, including mid-RUN or mid-DONE. Any operation in flight is discarded with no result output.
- State IDLE (in_ready=1):
  - On in_valid=1 at an edge: latch a into A_r.
  - Latch b into B_r, or ~b if op_sub=1.
  - Set carry register = op_sub; idx=0; go to RUN.
- State RUN (busy=1, in_ready=0):
  - Each cycle the adder slice computes A_r[idx], B_r[idx] and the carry register.
  - Its 8-bit sum is written to result byte idx at the edge, and its carry-out to the carry register.
  - At idx = NBYTES-1:
    - carry_out = slice carry.
    - overflow = (carry into bit W-1) XOR (carry out of bit W-1).
    - zero = (full W-bit result == 0), using the byte just written.
    - Go to DONE.
  - Otherwise idx increments.
  - in_valid is ignored; a, b and op_sub may change freely.
- State DONE (out_valid=1):
  - result and flags are held stable until out_ready=1 at an edge.
  - On that edge go to IDLE, with out_valid=0 and in_ready=1 the following cycle.
  - out_valid does not drop without out_ready.
  - result and flags keep their last values in IDLE until the next completion.
  - result bytes are not cleared on accept; intermediate bytes change during RUN. Consumers use result only while out_valid=1.
- Timing:
  - Accept edge at cycle k; out_valid rises after edge k+NBYTES.
  - Minimum request-to-request spacing is NBYTES+2 cycles, since no new accept happens in the same cycle as the result handshake.
- Width and arithmetic:
  - Arithmetic is modulo 2^W; carry chain across bytes is exact.
  - Subtract uses the ~B + 1 form.
  - A-B with A<B (unsigned) gives carry_out=0.
- No X propagation: all state registers are reset; idx width = clog2(NBYTES).

Test Plan:
- NBYTES=4, add 0x000000FF + 0x00000001 -> result 0x00000100, carry_out=0, overflow=0, zero=0; out_valid exactly 4 cycles after the accept edge.
- Add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry_out=1, overflow=0, zero=1.
- Sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, carry_out=1, overflow=1; sub 0x00000005 - 0x00000007 -> 0xFFFFFFFE, carry_out=0, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and new operands toggling -> out_valid and result stay stable, in_ready=0, no second accept; out_ready=1 -> IDLE, next request accepted one cycle later.
- Operand change mid-RUN: change a, b and op_sub after accept -> result reflects the latched operands only (0x12345678 + 0x11111111 = 0x23456789).
- rst_n=0 at RUN idx=2 -> next cycle IDLE with in_ready=1, out_valid=0 and all outputs 0; a fresh request after reset completes correctly.
